// File: rtl/grad_abs_bin_pipe.sv
// Three-stage multi-lane gradient unit: |gx|/|gy| with saturation, L1 or max+min/2
// magnitude, and a 9-bin (20 deg) unsigned orientation index, behind a global-stall handshake.
module grad_abs_bin_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             mag_mode,
  input  logic [LANES*(DATA_WIDTH+1)-1:0]  gx_in,
  input  logic [LANES*(DATA_WIDTH+1)-1:0]  gy_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*DATA_WIDTH-1:0]      abs_gx,
  output logic [LANES*DATA_WIDTH-1:0]      abs_gy,
  output logic [LANES*(DATA_WIDTH+1)-1:0]  mag,
  output logic [LANES*4-1:0]               bin,
  output logic [LANES-1:0]                 sat
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned GW = DATA_WIDTH + 1;
  localparam int unsigned PW = DATA_WIDTH + 11;
  localparam int unsigned NT = 4;

  // tan(20/40/60/80 deg) in Q8
  function automatic logic [PW-1:0] tan_q8(input int unsigned idx);
    case (idx)
      0:       return PW'(93);
      1:       return PW'(215);
      2:       return PW'(443);
      default: return PW'(1452);
    endcase
  endfunction

  // {sat, |x|}; the most negative code clamps to all-ones
  function automatic logic [DW:0] abs_sat(input logic [GW-1:0] x);
    logic [GW-1:0] neg;
    neg = -x;
    if (x == {1'b1, {DW{1'b0}}}) return {1'b1, {DW{1'b1}}};
    else if (x[DW])              return {1'b0, neg[DW-1:0]};
    else                         return {1'b0, x[DW-1:0]};
  endfunction

  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  logic [LANES-1:0][GW-1:0] w_gx, w_gy;
  logic [LANES-1:0][DW-1:0] w_ax, w_ay;
  logic [LANES-1:0]         w_satx, w_saty, w_upper, w_zero;

  always_comb begin
    w_gx    = gx_in;
    w_gy    = gy_in;
    w_ax    = '0;
    w_ay    = '0;
    w_satx  = '0;
    w_saty  = '0;
    w_upper = '0;
    w_zero  = '0;
    for (int l = 0; l < LANES; l++) begin
      {w_satx[l], w_ax[l]} = abs_sat(w_gx[l]);
      {w_saty[l], w_ay[l]} = abs_sat(w_gy[l]);
      w_upper[l] = (w_gx[l][DW] ^ w_gy[l][DW]) && (|w_gx[l]) && (|w_gy[l]);
      w_zero[l]  = !(|w_gx[l]) && !(|w_gy[l]);
    end
  end

  logic                     r_s1_valid, r_s1_mode;
  logic [LANES-1:0][DW-1:0] r_s1_ax, r_s1_ay;
  logic [LANES-1:0]         r_s1_sat, r_s1_upper, r_s1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_ax    <= '0;
      r_s1_ay    <= '0;
      r_s1_sat   <= '0;
      r_s1_upper <= '0;
      r_s1_zero  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= mag_mode;
      r_s1_ax    <= w_ax;
      r_s1_ay    <= w_ay;
      r_s1_sat   <= w_satx | w_saty;
      r_s1_upper <= w_upper;
      r_s1_zero  <= w_zero;
    end
  end

  logic [LANES-1:0][DW-1:0] w_max, w_min;
  logic [LANES-1:0][GW-1:0] w_mag;
  logic [LANES-1:0][PW-1:0] w_p;
  logic [LANES-1:0][NT-1:0] w_ge;

  // P = |gy|<<8 against |gx|*T, full-width products
  always_comb begin
    w_max = '0;
    w_min = '0;
    w_mag = '0;
    w_p   = '0;
    w_ge  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_max[l] = (r_s1_ax[l] > r_s1_ay[l]) ? r_s1_ax[l] : r_s1_ay[l];
      w_min[l] = (r_s1_ax[l] > r_s1_ay[l]) ? r_s1_ay[l] : r_s1_ax[l];
      w_mag[l] = r_s1_mode ? GW'(w_max[l]) + GW'(w_min[l] >> 1)
                           : GW'(r_s1_ax[l]) + GW'(r_s1_ay[l]);
      w_p[l]   = PW'({r_s1_ay[l], 8'd0});
      for (int t = 0; t < NT; t++) begin
        w_ge[l][t] = w_p[l] >= PW'(r_s1_ax[l]) * tan_q8(t);
      end
    end
  end

  logic                     r_s2_valid;
  logic [LANES-1:0][DW-1:0] r_s2_ax, r_s2_ay;
  logic [LANES-1:0][GW-1:0] r_s2_mag;
  logic [LANES-1:0][NT-1:0] r_s2_ge;
  logic [LANES-1:0]         r_s2_sat, r_s2_upper, r_s2_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_ax    <= '0;
      r_s2_ay    <= '0;
      r_s2_mag   <= '0;
      r_s2_ge    <= '0;
      r_s2_sat   <= '0;
      r_s2_upper <= '0;
      r_s2_zero  <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_ax    <= r_s1_ax;
      r_s2_ay    <= r_s1_ay;
      r_s2_mag   <= w_mag;
      r_s2_ge    <= w_ge;
      r_s2_sat   <= r_s1_sat;
      r_s2_upper <= r_s1_upper;
      r_s2_zero  <= r_s1_zero;
    end
  end

  // gx==0 yields s=4 naturally since every product is zero
  logic [LANES-1:0][2:0] w_s;
  logic [LANES-1:0][3:0] w_bin;

  always_comb begin
    w_s   = '0;
    w_bin = '0;
    for (int l = 0; l < LANES; l++) begin
      w_s[l] = 3'(r_s2_ge[l][0]) + 3'(r_s2_ge[l][1]) + 3'(r_s2_ge[l][2]) + 3'(r_s2_ge[l][3]);
      if (r_s2_zero[l])       w_bin[l] = 4'd0;
      else if (r_s2_upper[l]) w_bin[l] = 4'd8 - 4'(w_s[l]);
      else                    w_bin[l] = 4'(w_s[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      abs_gx    <= '0;
      abs_gy    <= '0;
      mag       <= '0;
      bin       <= '0;
      sat       <= '0;
    end else if (w_advance) begin
      out_valid <= r_s2_valid;
      abs_gx    <= r_s2_ax;
      abs_gy    <= r_s2_ay;
      mag       <= r_s2_mag;
      bin       <= w_bin;
      sat       <= r_s2_sat;
    end
  end

endmodule

// File: tb/tb_grad_abs_bin_pipe.sv
// Scoreboard bench for grad_abs_bin_pipe: directed spec cases, backpressure,
// mid-stream reset and randomized beats against an arithmetic reference model.
module tb_grad_abs_bin_pipe;

  localparam int unsigned DW   = 9;
  localparam int unsigned L    = 4;
  localparam int unsigned GW   = DW + 1;
  localparam int          MAXV = (1 << DW) - 1;

  typedef struct packed {
    logic [L*DW-1:0] agx;
    logic [L*DW-1:0] agy;
    logic [L*GW-1:0] mag;
    logic [L*4-1:0]  bin;
    logic [L-1:0]    sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            mag_mode = 1'b0;
  logic            out_ready = 1'b1;
  logic [L*GW-1:0] gx_in = '0;
  logic [L*GW-1:0] gy_in = '0;
  logic            in_ready, out_valid;
  logic [L*DW-1:0] abs_gx, abs_gy;
  logic [L*GW-1:0] mag;
  logic [L*4-1:0]  bin;
  logic [L-1:0]    sat;

  always #5 clk = ~clk;

  grad_abs_bin_pipe #(.DATA_WIDTH(DW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mag_mode(mag_mode),
    .gx_in(gx_in), .gy_in(gy_in), .out_valid(out_valid), .out_ready(out_ready),
    .abs_gx(abs_gx), .abs_gy(abs_gy), .mag(mag), .bin(bin), .sat(sat)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Orientation from the angle rules: count tan thresholds that |gy|/|gx| reaches.
  function automatic exp_t model(input logic [L*GW-1:0] gxv, input logic [L*GW-1:0] gyv,
                                 input logic mode);
    exp_t e;
    logic signed [GW-1:0] sx, sy;
    int gx, gy, ax, ay, mx, mn, mg, s, b;
    bit st, up;
    int tq[4];
    tq = '{93, 215, 443, 1452};
    e  = '0;
    for (int l = 0; l < L; l++) begin
      sx = gxv[l*GW +: GW];
      sy = gyv[l*GW +: GW];
      gx = int'(sx);
      gy = int'(sy);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      st = 1'b0;
      if (ax > MAXV) begin ax = MAXV; st = 1'b1; end
      if (ay > MAXV) begin ay = MAXV; st = 1'b1; end
      up = (gx != 0) && (gy != 0) && ((gx < 0) != (gy < 0));
      mx = (ax > ay) ? ax : ay;
      mn = (ax > ay) ? ay : ax;
      mg = mode ? mx + mn / 2 : ax + ay;
      s  = 0;
      for (int t = 0; t < 4; t++) if (ay * 256 >= ax * tq[t]) s++;
      if (gx == 0 && gy != 0) s = 4;
      b = (gx == 0 && gy == 0) ? 0 : (up ? 8 - s : s);
      e.agx[l*DW +: DW] = DW'(ax);
      e.agy[l*DW +: DW] = DW'(ay);
      e.mag[l*GW +: GW] = GW'(mg);
      e.bin[l*4 +: 4]   = 4'(b);
      e.sat[l]          = st;
    end
    return e;
  endfunction

  function automatic logic [L*GW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {GW'(a3), GW'(a2), GW'(a1), GW'(a0)};
  endfunction

  function automatic logic [L*GW-1:0] rand_vec();
    logic [L*GW-1:0] v;
    int sel;
    v = '0;
    for (int l = 0; l < L; l++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      v[l*GW +: GW] = '0;
      else if (sel == 1) v[l*GW +: GW] = {1'b1, {DW{1'b0}}};
      else               v[l*GW +: GW] = GW'($urandom);
    end
    return v;
  endfunction

  // Present a beat, hold until accepted, then drop in_valid after the accepting edge
  task automatic send_beat(input logic [L*GW-1:0] gxv, input logic [L*GW-1:0] gyv, input logic mode);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    gx_in    = gxv;
    gy_in    = gyv;
    mag_mode = mode;
    #1;
    guard = 0;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end else begin
      exp_q.push_back(model(gxv, gyv, mode));
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    chk("drain", 160'(exp_q.size()), 160'(0));
  endtask

  always @(posedge clk) begin
    #3;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  exp_t got, held, e;
  bit   stall_prev = 1'b0;

  always @(negedge clk) begin
    #2;
    got = {abs_gx, abs_gy, mag, bin, sat};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 160'(out_valid), 160'(1));
        chk("hold_data", got, held);
      end
      stall_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", got);
        end else begin
          e = exp_q.pop_front();
          chk("abs_gx", 160'(abs_gx), 160'(e.agx));
          chk("abs_gy", 160'(abs_gy), 160'(e.agy));
          chk("mag", 160'(mag), 160'(e.mag));
          chk("bin", 160'(bin), 160'(e.bin));
          chk("sat", 160'(sat), 160'(e.sat));
        end
      end else if (out_valid) begin
        chk("in_ready_stall", 160'(in_ready), 160'(0));
        held       = got;
        stall_prev = 1'b1;
      end
    end
  end

  initial begin
    int n;
    logic [L*GW-1:0] dgx, dgy;
    rdy_mode = 0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_data", {abs_gx, abs_gy, mag, bin, sat}, 160'(0));
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 160'(in_ready), 160'(1));

    // basic, upper half, axis cases; then latency of the first beat
    dgx = pack4(30, -30, 10, 0);
    dgy = pack4(10, 10, -30, 100);
    send_beat(dgx, dgy, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", 160'(n), 160'(2));
    send_beat(dgx, dgy, 1'b1);
    // saturation, threshold equality, zero, double saturation
    send_beat(pack4(-512, 256, 0, -512), pack4(0, 93, 0, -512), 1'b0);
    send_beat(pack4(-512, 256, 0, -512), pack4(0, 93, 0, -512), 1'b1);
    drain();

    // backpressure window in the middle of a 10-beat stream
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 1;
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) send_beat(rand_vec(), rand_vec(), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_mid_out_valid", 160'(out_valid), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", 160'(in_ready), 160'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_stale", 160'(out_valid), 160'(0));

    // randomized stream with random backpressure and per-beat mode
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      send_beat(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
